// File: rtl/time_counter_12h.sv
// Timekeeping core for a 12-hour clock: divides clk down to a 1 s tick and
// keeps HH:MM:SS plus an AM/PM flag as packed BCD digits. Two edge-detected
// buttons advance minutes and hours. Every output comes straight from a register.
module time_counter_12h #(
  parameter int TICK_DIV = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [0:0] hr_tens,
  output logic       pm,
  output logic       sec_tick
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          set_min_prev_q, set_hr_prev_q;
  // Cleared by reset and set after the first clock: a button that is still
  // held when reset releases must not look like a fresh press.
  logic          arm_q;

  logic [3:0] sec_ones_q, sec_ones_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [2:0] min_tens_q, min_tens_d;
  logic [3:0] hr_ones_q, hr_ones_d;
  logic [0:0] hr_tens_q, hr_tens_d;
  logic       pm_q, pm_d;
  logic       sec_tick_q, sec_tick_d;

  logic       min_evt, hr_evt, set_evt, tick;
  logic       sec_at_max, min_at_max;
  logic [3:0] sec_adv_ones, min_adv_ones, hr_adv_ones;
  logic [2:0] sec_adv_tens, min_adv_tens;
  logic [0:0] hr_adv_tens;
  logic       pm_adv;

  // Per-field "value + 1" candidates, shared by the tick chain and the buttons.
  always_comb begin
    sec_at_max   = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
    min_at_max   = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);

    sec_adv_ones = sec_ones_q + 4'd1;
    sec_adv_tens = sec_tens_q;
    if (sec_ones_q == 4'd9) begin
      sec_adv_ones = 4'd0;
      sec_adv_tens = sec_at_max ? 3'd0 : sec_tens_q + 3'd1;
    end

    min_adv_ones = min_ones_q + 4'd1;
    min_adv_tens = min_tens_q;
    if (min_ones_q == 4'd9) begin
      min_adv_ones = 4'd0;
      min_adv_tens = min_at_max ? 3'd0 : min_tens_q + 3'd1;
    end

    // Hours run 12, 01 .. 11, 12; only the step into 12 flips AM/PM.
    hr_adv_tens = hr_tens_q;
    hr_adv_ones = hr_ones_q + 4'd1;
    pm_adv      = pm_q;
    if (hr_tens_q == 1'b1 && hr_ones_q == 4'd2) begin
      hr_adv_tens = 1'b0;
      hr_adv_ones = 4'd1;
    end else if (hr_tens_q == 1'b1 && hr_ones_q == 4'd1) begin
      hr_adv_ones = 4'd2;
      pm_adv      = ~pm_q;
    end else if (hr_ones_q == 4'd9) begin
      hr_adv_tens = 1'b1;
      hr_adv_ones = 4'd0;
    end
  end

  // Button edges, prescaler and next time; a button press pre-empts the tick.
  always_comb begin
    min_evt = set_min & ~set_min_prev_q & arm_q;
    hr_evt  = set_hr & ~set_hr_prev_q & arm_q;
    set_evt = min_evt | hr_evt;

    tick    = 1'b0;
    presc_d = presc_q;
    if (set_evt) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    hr_ones_d  = hr_ones_q;
    hr_tens_d  = hr_tens_q;
    pm_d       = pm_q;
    sec_tick_d = tick;

    if (tick) begin
      sec_ones_d = sec_adv_ones;
      sec_tens_d = sec_adv_tens;
      if (sec_at_max) begin
        min_ones_d = min_adv_ones;
        min_tens_d = min_adv_tens;
        if (min_at_max) begin
          hr_ones_d = hr_adv_ones;
          hr_tens_d = hr_adv_tens;
          pm_d      = pm_adv;
        end
      end
    end

    // Minute set wraps 59 -> 00 without touching hours.
    if (min_evt) begin
      min_ones_d = min_adv_ones;
      min_tens_d = min_adv_tens;
      sec_ones_d = 4'd0;
      sec_tens_d = 3'd0;
    end

    if (hr_evt) begin
      hr_ones_d = hr_adv_ones;
      hr_tens_d = hr_adv_tens;
      pm_d      = pm_adv;
    end
  end

  // State registers; reset lands on 12:00:00 AM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q        <= '0;
      set_min_prev_q <= 1'b0;
      set_hr_prev_q  <= 1'b0;
      arm_q          <= 1'b0;
      sec_ones_q     <= 4'd0;
      sec_tens_q     <= 3'd0;
      min_ones_q     <= 4'd0;
      min_tens_q     <= 3'd0;
      hr_ones_q      <= 4'd2;
      hr_tens_q      <= 1'b1;
      pm_q           <= 1'b0;
      sec_tick_q     <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      set_min_prev_q <= set_min;
      set_hr_prev_q  <= set_hr;
      arm_q          <= 1'b1;
      sec_ones_q     <= sec_ones_d;
      sec_tens_q     <= sec_tens_d;
      min_ones_q     <= min_ones_d;
      min_tens_q     <= min_tens_d;
      hr_ones_q      <= hr_ones_d;
      hr_tens_q      <= hr_tens_d;
      pm_q           <= pm_d;
      sec_tick_q     <= sec_tick_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign hr_ones  = hr_ones_q;
  assign hr_tens  = hr_tens_q;
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_counter_12h.sv
// Directed bench for time_counter_12h with a 4-cycle second.
module tb_time_counter_12h;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset, en, set_min, set_hr;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens;
  logic [0:0] hr_tens;
  logic       pm, sec_tick;

  int n_checks = 0;
  int n_fail   = 0;

  time_counter_12h #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .en(en), .set_min(set_min), .set_hr(set_hr),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hr_ones(hr_ones), .hr_tens(hr_tens),
    .pm(pm), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_TICKS, OP_PRESS_MIN, OP_HOLD_MIN, OP_PRESS_HR, OP_PRESS_BOTH} op_e;
  typedef struct {
    op_e        op;
    int         n;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(op_e op, int n, logic [7:0] hh, logic [7:0] mm,
                              logic [7:0] ss, logic p);
    vec_t v;
    v.op = op; v.n = n; v.hh = hh; v.mm = mm; v.ss = ss; v.pm = p;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_time(input string name, input logic [7:0] hh,
                            input logic [7:0] mm, input logic [7:0] ss, input logic p);
    logic [24:0] act, exp_v;
    act   = {3'b000, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones, pm};
    exp_v = {hh, mm, ss, p};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h:%h:%h pm=%b, expected %h:%h:%h pm=%b", name,
               act[24:17], act[16:9], act[8:1], act[0], hh, mm, ss, p);
    end else begin
      $display("ok   %s: %h:%h:%h pm=%b", name, hh, mm, ss, p);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Enable for exactly n seconds worth of cycles, starting from prescaler 0.
  task automatic run_ticks(input int n, output int seen);
    seen = 0;
    en = 1'b1;
    for (int i = 0; i < n * TD; i++) begin
      cyc(1);
      if (sec_tick === 1'b1) seen++;
    end
    en = 1'b0;
  endtask

  task automatic press(input logic m, input logic h, input int hold);
    set_min = m;
    set_hr  = h;
    cyc(hold);
    set_min = 1'b0;
    set_hr  = 1'b0;
    cyc(1);
  endtask

  initial begin
    int seen;
    int wait_cyc;
    reset = 1'b1; en = 1'b0; set_min = 1'b0; set_hr = 1'b0;

    vecs[0]  = mk(OP_TICKS,      33, 8'h12, 8'h00, 8'h37, 1'b0);
    vecs[1]  = mk(OP_HOLD_MIN,   10, 8'h12, 8'h01, 8'h00, 1'b0);
    vecs[2]  = mk(OP_PRESS_MIN,  58, 8'h12, 8'h59, 8'h00, 1'b0);
    vecs[3]  = mk(OP_PRESS_MIN,   1, 8'h12, 8'h00, 8'h00, 1'b0);
    vecs[4]  = mk(OP_PRESS_HR,    1, 8'h01, 8'h00, 8'h00, 1'b0);
    vecs[5]  = mk(OP_PRESS_HR,   10, 8'h11, 8'h00, 8'h00, 1'b0);
    vecs[6]  = mk(OP_PRESS_MIN,  59, 8'h11, 8'h59, 8'h00, 1'b0);
    vecs[7]  = mk(OP_TICKS,      59, 8'h11, 8'h59, 8'h59, 1'b0);
    vecs[8]  = mk(OP_TICKS,       1, 8'h12, 8'h00, 8'h00, 1'b1);
    vecs[9]  = mk(OP_PRESS_MIN,  59, 8'h12, 8'h59, 8'h00, 1'b1);
    vecs[10] = mk(OP_TICKS,      59, 8'h12, 8'h59, 8'h59, 1'b1);
    vecs[11] = mk(OP_TICKS,       1, 8'h01, 8'h00, 8'h00, 1'b1);
    vecs[12] = mk(OP_TICKS,       5, 8'h01, 8'h00, 8'h05, 1'b1);
    vecs[13] = mk(OP_PRESS_HR,   10, 8'h11, 8'h00, 8'h05, 1'b1);
    vecs[14] = mk(OP_PRESS_HR,    1, 8'h12, 8'h00, 8'h05, 1'b0);
    vecs[15] = mk(OP_PRESS_BOTH,  1, 8'h01, 8'h01, 8'h00, 1'b0);
    vecs[16] = mk(OP_PRESS_MIN,  58, 8'h01, 8'h59, 8'h00, 1'b0);
    vecs[17] = mk(OP_PRESS_BOTH,  1, 8'h02, 8'h00, 8'h00, 1'b0);
    vecs[18] = mk(OP_TICKS,      61, 8'h02, 8'h01, 8'h01, 1'b0);
    vecs[19] = mk(OP_PRESS_HR,    9, 8'h11, 8'h01, 8'h01, 1'b0);
    vecs[20] = mk(OP_PRESS_HR,    1, 8'h12, 8'h01, 8'h01, 1'b1);
    vecs[21] = mk(OP_PRESS_HR,    1, 8'h01, 8'h01, 8'h01, 1'b1);

    // Reset state and hold with en low.
    cyc(2);
    check_time("reset_state", 8'h12, 8'h00, 8'h00, 1'b0);
    check_int("reset_sec_tick", int'(sec_tick), 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (sec_tick !== 1'b0) seen++;
    end
    check_int("hold_no_ticks", seen, 0);
    check_time("hold_time", 8'h12, 8'h00, 8'h00, 1'b0);

    // Tick cadence: pulse on every 4th cycle after enabling.
    en = 1'b1;
    for (int c = 1; c <= 4 * TD; c++) begin
      cyc(1);
      check_int($sformatf("cadence_c%0d", c), int'(sec_tick), (c % TD == 0) ? 1 : 0);
    end
    en = 1'b0;
    check_time("cadence_time", 8'h12, 8'h00, 8'h04, 1'b0);

    // Table of button/tick operations.
    for (int i = 0; i < 22; i++) begin
      case (vecs[i].op)
        OP_TICKS: begin
          run_ticks(vecs[i].n, seen);
          check_int($sformatf("vec%0d_ticks", i), seen, vecs[i].n);
        end
        OP_PRESS_MIN:  for (int k = 0; k < vecs[i].n; k++) press(1'b1, 1'b0, 1);
        OP_HOLD_MIN:   press(1'b1, 1'b0, vecs[i].n);
        OP_PRESS_HR:   for (int k = 0; k < vecs[i].n; k++) press(1'b0, 1'b1, 1);
        OP_PRESS_BOTH: for (int k = 0; k < vecs[i].n; k++) press(1'b1, 1'b1, 1);
        default: ;
      endcase
      check_time($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].pm);
    end

    // Collision: set_min rises on the prescaler-wrap cycle at 12:00:59.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_time("coll_reset", 8'h12, 8'h00, 8'h00, 1'b0);
    run_ticks(59, seen);
    check_time("coll_preload", 8'h12, 8'h00, 8'h59, 1'b0);
    en = 1'b1;
    cyc(TD - 1);
    set_min = 1'b1;
    cyc(1);
    check_int("coll_sec_tick", int'(sec_tick), 0);
    check_time("coll_time", 8'h12, 8'h01, 8'h00, 1'b0);
    wait_cyc = 0;
    while (sec_tick !== 1'b1 && wait_cyc < 3 * TD) begin
      cyc(1);
      wait_cyc++;
    end
    check_int("coll_next_tick_cycles", wait_cyc, TD);
    set_min = 1'b0;
    en = 1'b0;
    check_time("coll_after_tick", 8'h12, 8'h01, 8'h01, 1'b0);

    // Reset mid-count with set_hr held through release.
    en = 1'b1;
    cyc(2);
    set_hr = 1'b1;
    reset  = 1'b1;
    #1;
    check_time("midreset_async", 8'h12, 8'h00, 8'h00, 1'b0);
    check_int("midreset_sec_tick", int'(sec_tick), 0);
    en = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(5);
    check_time("held_btn_after_reset", 8'h12, 8'h00, 8'h00, 1'b0);
    set_hr = 1'b0;
    cyc(1);
    press(1'b0, 1'b1, 1);
    check_time("press_after_reset", 8'h01, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_counter_12h.md
Name: time_counter_12h

Overview:
Timekeeping core of the 12-hour digital clock. It divides the system clock down to a 1 Hz tick and keeps HH:MM:SS plus an AM/PM flag as packed BCD digits. The digits and the AM/PM flag feed the downstream seven-segment scan/decode stage, which drives seg/dp/dispEn. Two pushbutton inputs set the time.

Parameters:
TICK_DIV, 10000000, system clock cycles per second tick; must be ≥ 2; prescaler width is $clog2(TICK_DIV).

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  run enable; 1 = time advances, 0 = prescaler and time hold
set_min  input  1  minute-set button, already debounced and synchronous to clk; acts on its rising edge
set_hr  input  1  hour-set button, already debounced and synchronous to clk; acts on its rising edge
sec_ones  output  4  seconds units, BCD 0-9
sec_tens  output  3  seconds tens, 0-5
min_ones  output  4  minutes units, BCD 0-9
min_tens  output  3  minutes tens, 0-5
hr_ones  output  4  hours units, BCD 0-9
hr_tens  output  1  hours tens, 0-1
pm  output  1  0 = AM, 1 = PM
sec_tick  output  1  one-cycle pulse on each cycle in which the seconds value advanced

Behaviour:
- Reset (asynchronous, active-high) forces 12:00:00 AM:
  - hr_tens=1, hr_ones=2, all other digits 0, pm=0.
  - sec_tick=0, prescaler=0, edge-detect registers=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Prescaler:
  - While en=1 and no set event is present, it counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1, it wraps to 0 and a tick occurs.
  - While en=0, the prescaler holds its value. No tick occurs.
- Tick: on the same clock edge that wraps the prescaler, sec_tick is registered to 1 and the time advances one second. sec_tick is 0 on all other cycles.
- Rollover chain on a tick:
  - sec 59 → 00, with carry to minutes.
  - min 59 → 00, with carry to hours.
  - Hours sequence: 12 → 01 → 02 … 11 → 12.
  - The 11 → 12 transition toggles pm. The 12 → 01 transition does not.
  - So 11:59:59 AM → 12:00:00 PM, and 12:59:59 PM → 01:00:00 PM.
- Set events:
  - Rising edge of set_min or set_hr is detected with one internal register per input (previous-value compare).
  - A held-high input produces exactly one event.
  - Events are honoured regardless of en.
- set_min event:
  - minutes +1, wrapping 59 → 00 with no carry into hours.
  - Seconds cleared to 00.
  - Prescaler cleared to 0.
- set_hr event:
  - hours +1 using the same 12-hour sequence; 11 → 12 toggles pm.
  - Minutes and seconds unchanged.
  - Prescaler cleared to 0.
- A set event and a would-be tick in the same cycle: the set event wins. No tick occurs, sec_tick=0, and no carry from seconds is applied that cycle.
- set_min and set_hr events in the same cycle: both apply (minutes +1 with seconds cleared, hours +1). Minute wrap still never carries into hours.
- Digits never leave their legal ranges. Illegal states are unreachable from reset.
- Reset asserted mid-count or mid-button-press returns to 12:00:00 AM immediately. A set input still held high when reset releases does not generate an event.

Test Plan:
- Reset/hold: assert reset, release with en=0, wait 20 cycles → 12:00:00 AM, sec_tick never 1. Prescaler frozen: enabling later gives first tick after exactly TICK_DIV cycles.
- Tick cadence (TICK_DIV=4, en=1): sec_tick high on every 4th cycle only. After 4 ticks, display reads 12:00:04 AM.
- AM/PM rollover: preload to 11:59:59 AM via set presses plus ticks, one tick → 12:00:00 PM (hr_tens=1, hr_ones=2, pm=1). Continue to 12:59:59 PM, one tick → 01:00:00 PM.
- set_min: from 12:00:37, hold set_min high 10 cycles → single event, 12:01:00, prescaler restarts. From 12:59, press → 12:00, hours unchanged.
- set_hr: from 11:xx AM, press → 12:xx PM. From 12:xx PM, press → 01:xx PM, minutes and seconds unchanged.
- Collision: align set_min rising edge with the prescaler-wrap cycle at 12:00:59 → result 12:01:00, sec_tick stays 0 that cycle, next tick TICK_DIV cycles later. Then assert reset mid-count → immediate 12:00:00 AM.
